// File: rtl/view_ctrl.sv
// ---------------------------------------------------------------------------
// view_ctrl -- cursor / viewport controller for a cell-map display.
//
// Button pulses are latched as one 3-bit command (fixed priority) and held
// until the next frame_start.  The command is then applied in a single APPLY
// cycle, so every visible output changes on one clock edge, during vertical
// blanking.  Edit mode moves the cursor and the window follows it.  Run mode
// pans the window.  Zoom sets the visible cell count to 4, 8, 16 or 32.
//
// Optional build macro: VIEW_CTRL_WRAP_EN
//   defined   -> the edit-mode cursor wraps around at the map edges
//   undefined -> the edit-mode cursor saturates at the map edges
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   btn_*               single-cycle command pulses
//   frame_start         one-cycle pulse at start of vertical blanking
//   mode                MODE_EDIT (0) / MODE_RUN (1)
//   cur_x, cur_y        cursor cell
//   win_x, win_y        top-left visible cell
//   visi_cell_num       visible cells per axis
//   cell_wr_en          one-cycle toggle request, address on cell_wr_x/y
//   cmd_pending         a command is captured and not yet applied
//   state_dbg           FSM state (0 IDLE, 1 PENDING, 2 APPLY)
//
// Handshake: the command pulses have no ready signal.  Only the first pulse
// seen in IDLE is taken.  Pulses that arrive while a command is pending or
// applying are dropped.
// ---------------------------------------------------------------------------
`ifndef MODE_EDIT
`define MODE_EDIT 1'b0
`endif
`ifndef MODE_RUN
`define MODE_RUN 1'b1
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module view_ctrl #(
  parameter int MAP_WIDTH  = 64,
  parameter int MAP_HEIGHT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_zoom_in,
  input  logic                   btn_zoom_out,
  input  logic                   btn_mode,
  input  logic                   btn_toggle,
  input  logic                   frame_start,
  output logic                   mode,
  output logic [`ADDR_WIDTH-1:0] cur_x,
  output logic [`ADDR_WIDTH-1:0] cur_y,
  output logic [`ADDR_WIDTH-1:0] win_x,
  output logic [`ADDR_WIDTH-1:0] win_y,
  output logic [7:0]             visi_cell_num,
  output logic                   cell_wr_en,
  output logic [`ADDR_WIDTH-1:0] cell_wr_x,
  output logic [`ADDR_WIDTH-1:0] cell_wr_y,
  output logic                   cmd_pending,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_APPLY   = 2'd2;

  localparam logic [2:0] C_MODE   = 3'd0;
  localparam logic [2:0] C_ZIN    = 3'd1;
  localparam logic [2:0] C_ZOUT   = 3'd2;
  localparam logic [2:0] C_UP     = 3'd3;
  localparam logic [2:0] C_DOWN   = 3'd4;
  localparam logic [2:0] C_LEFT   = 3'd5;
  localparam logic [2:0] C_RIGHT  = 3'd6;
  localparam logic [2:0] C_TOGGLE = 3'd7;

  localparam logic [8:0] MAP_W = 9'(MAP_WIDTH);
  localparam logic [8:0] MAP_H = 9'(MAP_HEIGHT);

  logic [1:0] state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic       mode_q, mode_d;
  logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0] win_x_q, win_x_d, win_y_q, win_y_d;
  logic [7:0] visi_q, visi_d;
  logic       wr_en_q, wr_en_d;

  // Results of applying cmd_q to the current view (9-bit, no wrap).
  logic       n_mode;
  logic [8:0] n_cx, n_cy, n_wx, n_wy, n_vis;

  logic any_btn;
  assign any_btn = btn_up | btn_down | btn_left | btn_right |
                   btn_zoom_in | btn_zoom_out | btn_mode | btn_toggle;

  // Window origin that keeps cursor c inside [w, w+v).
  function automatic logic [8:0] follow(input logic [8:0] c, input logic [8:0] w,
                                        input logic [8:0] v);
    if (c < w)          return c;
    else if (c >= w + v) return c - v + 9'd1;
    else                 return w;
  endfunction

  function automatic logic [8:0] cur_dec(input logic [8:0] c, input logic [8:0] lim);
    if (c == 9'd0) begin
`ifdef VIEW_CTRL_WRAP_EN
      return lim - 9'd1;
`else
      return c;
`endif
    end
    return c - 9'd1;
  endfunction

  function automatic logic [8:0] cur_inc(input logic [8:0] c, input logic [8:0] lim);
    if (c == lim - 9'd1) begin
`ifdef VIEW_CTRL_WRAP_EN
      return 9'd0;
`else
      return c;
`endif
    end
    return c + 9'd1;
  endfunction

  // FSM and command capture.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_IDLE: begin
        if (any_btn) begin
          state_d = S_PENDING;
          if (btn_mode)          cmd_d = C_MODE;
          else if (btn_zoom_in)  cmd_d = C_ZIN;
          else if (btn_zoom_out) cmd_d = C_ZOUT;
          else if (btn_up)       cmd_d = C_UP;
          else if (btn_down)     cmd_d = C_DOWN;
          else if (btn_left)     cmd_d = C_LEFT;
          else if (btn_right)    cmd_d = C_RIGHT;
          else                   cmd_d = C_TOGGLE;
        end
      end
      S_PENDING: if (frame_start) state_d = S_APPLY;
      S_APPLY:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Command datapath.
  always_comb begin
    n_mode = mode_q;
    n_cx   = {1'b0, cur_x_q};
    n_cy   = {1'b0, cur_y_q};
    n_wx   = {1'b0, win_x_q};
    n_wy   = {1'b0, win_y_q};
    n_vis  = {1'b0, visi_q};
    case (cmd_q)
      C_MODE: n_mode = ~mode_q;
      C_ZIN, C_ZOUT: begin
        // At the 4 / 32 limits the command leaves everything unchanged.
        if ((cmd_q == C_ZIN) && (n_vis > 9'd4)) n_vis = n_vis >> 1;
        else if ((cmd_q == C_ZOUT) && (n_vis < 9'd32)) n_vis = n_vis << 1;
        if (n_vis != {1'b0, visi_q}) begin
          if (n_wx > MAP_W - n_vis) n_wx = MAP_W - n_vis;
          if (n_wy > MAP_H - n_vis) n_wy = MAP_H - n_vis;
          if (mode_q == `MODE_EDIT) begin
            n_wx = follow(n_cx, n_wx, n_vis);
            n_wy = follow(n_cy, n_wy, n_vis);
          end
        end
      end
      C_UP: begin
        if (mode_q == `MODE_EDIT) begin
          n_cy = cur_dec(n_cy, MAP_H);
          n_wy = follow(n_cy, n_wy, n_vis);
        end else if (n_wy != 9'd0) begin
          n_wy = n_wy - 9'd1;
        end
      end
      C_DOWN: begin
        if (mode_q == `MODE_EDIT) begin
          n_cy = cur_inc(n_cy, MAP_H);
          n_wy = follow(n_cy, n_wy, n_vis);
        end else if (n_wy + n_vis < MAP_H) begin
          n_wy = n_wy + 9'd1;
        end
      end
      C_LEFT: begin
        if (mode_q == `MODE_EDIT) begin
          n_cx = cur_dec(n_cx, MAP_W);
          n_wx = follow(n_cx, n_wx, n_vis);
        end else if (n_wx != 9'd0) begin
          n_wx = n_wx - 9'd1;
        end
      end
      C_RIGHT: begin
        if (mode_q == `MODE_EDIT) begin
          n_cx = cur_inc(n_cx, MAP_W);
          n_wx = follow(n_cx, n_wx, n_vis);
        end else if (n_wx + n_vis < MAP_W) begin
          n_wx = n_wx + 9'd1;
        end
      end
      default: ;  // toggle: view unchanged, only the write strobe fires
    endcase
  end

  // Visible registers load only on the edge leaving APPLY.
  always_comb begin
    mode_d  = mode_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    visi_d  = visi_q;
    wr_en_d = 1'b0;
    if (state_q == S_APPLY) begin
      mode_d  = n_mode;
      cur_x_d = n_cx[7:0];
      cur_y_d = n_cy[7:0];
      win_x_d = n_wx[7:0];
      win_y_d = n_wy[7:0];
      visi_d  = n_vis[7:0];
      wr_en_d = (cmd_q == C_TOGGLE) && (mode_q == `MODE_EDIT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= C_MODE;
      mode_q  <= `MODE_EDIT;
      cur_x_q <= 8'd0;
      cur_y_q <= 8'd0;
      win_x_q <= 8'd0;
      win_y_q <= 8'd0;
      visi_q  <= 8'd16;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
      visi_q  <= visi_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign mode          = mode_q;
  assign cur_x         = cur_x_q;
  assign cur_y         = cur_y_q;
  assign win_x         = win_x_q;
  assign win_y         = win_y_q;
  assign visi_cell_num = visi_q;
  assign cell_wr_en    = wr_en_q;
  assign cell_wr_x     = cur_x_q;
  assign cell_wr_y     = cur_y_q;
  assign cmd_pending   = (state_q != S_IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_view_ctrl.sv
// ---------------------------------------------------------------------------
// tb_view_ctrl -- directed self-checking bench for view_ctrl (64x64 map).
// Expected values are worked out by hand from the command semantics.
// Inputs are driven 1 time unit after a rising edge.  Outputs are sampled
// at the same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_view_ctrl;

  localparam logic [7:0] B_MODE   = 8'h01;
  localparam logic [7:0] B_ZIN    = 8'h02;
  localparam logic [7:0] B_ZOUT   = 8'h04;
  localparam logic [7:0] B_UP     = 8'h08;
  localparam logic [7:0] B_DOWN   = 8'h10;
  localparam logic [7:0] B_LEFT   = 8'h20;
  localparam logic [7:0] B_RIGHT  = 8'h40;
  localparam logic [7:0] B_TOGGLE = 8'h80;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] btn;
  logic       frame_start;

  logic       mode, cell_wr_en, cmd_pending;
  logic [7:0] cur_x, cur_y, win_x, win_y, visi_cell_num, cell_wr_x, cell_wr_y;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  view_ctrl #(.MAP_WIDTH(64), .MAP_HEIGHT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_up        (btn[3]),
    .btn_down      (btn[4]),
    .btn_left      (btn[5]),
    .btn_right     (btn[6]),
    .btn_zoom_in   (btn[1]),
    .btn_zoom_out  (btn[2]),
    .btn_mode      (btn[0]),
    .btn_toggle    (btn[7]),
    .frame_start   (frame_start),
    .mode          (mode),
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .win_x         (win_x),
    .win_y         (win_y),
    .visi_cell_num (visi_cell_num),
    .cell_wr_en    (cell_wr_en),
    .cell_wr_x     (cell_wr_x),
    .cell_wr_y     (cell_wr_y),
    .cmd_pending   (cmd_pending),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  // One-cycle button pulse; returns just after the capture edge.
  task automatic pulse(input logic [7:0] b);
    step();
    btn = b;
    step();
    btn = 8'h00;
  endtask

  // One-cycle frame_start; returns just after the edge entering APPLY.
  task automatic frame();
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Full command; returns just after the edge leaving APPLY.
  task automatic do_cmd(input logic [7:0] b);
    pulse(b);
    frame();
    step();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    btn = 8'h00;
    frame_start = 1'b0;
    step();
    step();

    // Reset values
    check("rst_mode", mode, 0);
    check("rst_cur_x", cur_x, 0);
    check("rst_cur_y", cur_y, 0);
    check("rst_win_x", win_x, 0);
    check("rst_win_y", win_y, 0);
    check("rst_visi", visi_cell_num, 16);
    check("rst_wr_en", cell_wr_en, 0);
    check("rst_pending", cmd_pending, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b1;

    // Toggle right after reset release
    pulse(B_TOGGLE);
    check("tog_pending", cmd_pending, 1);
    check("tog_state_pend", state_dbg, 1);
    frame();
    check("tog_state_apply", state_dbg, 2);
    check("tog_wr_en_apply", cell_wr_en, 0);
    step();
    check("tog_wr_en", cell_wr_en, 1);
    check("tog_wr_x", cell_wr_x, 0);
    check("tog_wr_y", cell_wr_y, 0);
    check("tog_pending_clr", cmd_pending, 0);
    step();
    check("tog_wr_en_drop", cell_wr_en, 0);

    // 16 rights in edit mode, window follows once the cursor reaches 16
    for (int i = 0; i < 16; i++) begin
      pulse(B_RIGHT);
      check("right_pend_cur", cur_x, i);
      check("right_pend_win", win_x, (i > 15) ? i - 15 : 0);
      frame();
      step();
      check("right_cur", cur_x, i + 1);
      check("right_win", win_x, (i + 1 > 15) ? i + 1 - 15 : 0);
      check("right_wr_x", cell_wr_x, i + 1);
    end

    // frame_start in the capture cycle is ignored
    step();
    btn = B_DOWN;
    frame_start = 1'b1;
    step();
    btn = 8'h00;
    frame_start = 1'b0;
    step();
    step();
    check("same_cyc_state", state_dbg, 1);
    check("same_cyc_cur_y", cur_y, 0);
    frame();
    step();
    check("same_cyc_applied", cur_y, 1);

    // up + zoom_in together: zoom wins, extra pulses while pending dropped
    pulse(B_UP | B_ZIN);
    pulse(B_RIGHT | B_MODE);
    pulse(B_TOGGLE);
    frame();
    step();
    check("prio_visi", visi_cell_num, 8);
    check("prio_cur_y", cur_y, 1);
    check("prio_cur_x", cur_x, 16);
    check("prio_win_x", win_x, 9);
    check("prio_mode", mode, 0);
    check("prio_wr_en", cell_wr_en, 0);
    check("prio_pending", cmd_pending, 0);

    // Zoom walk with saturation at both ends
    do_cmd(B_ZOUT);
    check("zout16_visi", visi_cell_num, 16);
    check("zout16_win_x", win_x, 9);
    do_cmd(B_ZOUT);
    check("zout32_visi", visi_cell_num, 32);
    do_cmd(B_ZOUT);
    check("zout_sat_visi", visi_cell_num, 32);
    check("zout_sat_win_x", win_x, 9);
    do_cmd(B_ZIN);
    do_cmd(B_ZIN);
    do_cmd(B_ZIN);
    check("zin4_visi", visi_cell_num, 4);
    check("zin4_win_x", win_x, 13);
    check("zin4_win_y", win_y, 0);
    do_cmd(B_ZIN);
    check("zin_sat_visi", visi_cell_num, 4);
    check("zin_sat_win_x", win_x, 13);

    // Run mode panning and zoom clamp
    do_reset();
    do_cmd(B_MODE);
    check("run_mode", mode, 1);
    check("run_cur_x", cur_x, 0);
    for (int i = 0; i < 48; i++) do_cmd(B_RIGHT);
    check("run_pan_win_x", win_x, 48);
    check("run_pan_cur_x", cur_x, 0);
    do_cmd(B_RIGHT);
    check("run_pan_sat_hi", win_x, 48);
    do_cmd(B_UP);
    check("run_pan_sat_lo", win_y, 0);
    do_cmd(B_ZOUT);
    check("run_zout_visi", visi_cell_num, 32);
    check("run_zout_win_x", win_x, 32);
    do_cmd(B_TOGGLE);
    check("run_tog_wr_en", cell_wr_en, 0);
    do_cmd(B_LEFT);
    check("run_left_win_x", win_x, 31);
    do_cmd(B_DOWN);
    check("run_down_win_y", win_y, 1);

    // Edit cursor at 0 moving left / up
    do_reset();
    do_cmd(B_LEFT);
    do_cmd(B_UP);
`ifdef VIEW_CTRL_WRAP_EN
    check("edge_left_cur_x", cur_x, 63);
    check("edge_left_win_x", win_x, 48);
    check("edge_up_cur_y", cur_y, 63);
    check("edge_up_win_y", win_y, 48);
`else
    check("edge_left_cur_x", cur_x, 0);
    check("edge_left_win_x", win_x, 0);
    check("edge_up_cur_y", cur_y, 0);
    check("edge_up_win_y", win_y, 0);
`endif

    // Reset while PENDING
    do_reset();
    do_cmd(B_RIGHT);
    check("pre_rst_cur_x", cur_x, 1);
    pulse(B_TOGGLE);
    check("pre_rst_pending", cmd_pending, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_pend_pending", cmd_pending, 0);
    check("rst_pend_cur_x", cur_x, 0);
    check("rst_pend_visi", visi_cell_num, 16);
    check("rst_pend_state", state_dbg, 0);
    step();
    rst = 1'b1;
    frame();
    for (int i = 0; i < 4; i++) begin
      check("rst_pend_no_wr", cell_wr_en, 0);
      check("rst_pend_idle", cmd_pending, 0);
      step();
    end

    // Reset while APPLY
    pulse(B_RIGHT);
    frame();
    check("apply_state", state_dbg, 2);
    rst = 1'b0;
    #1;
    check("rst_apply_state", state_dbg, 0);
    step();
    rst = 1'b1;
    step();
    check("rst_apply_cur_x", cur_x, 0);

    // Command taken normally afterwards
    do_cmd(B_DOWN);
    do_cmd(B_TOGGLE);
    check("post_rst_wr_en", cell_wr_en, 1);
    check("post_rst_wr_x", cell_wr_x, 0);
    check("post_rst_wr_y", cell_wr_y, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
